// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: hex segment table and FSM state encoding shared by the display mux.
package seven_seg_pkg;
    localparam logic [1:0] S_LS_ON  = 2'd0;
    localparam logic [1:0] S_LS_OFF = 2'd1;
    localparam logic [1:0] S_MS_ON  = 2'd2;
    localparam logic [1:0] S_MS_OFF = 2'd3;
    // Active-high gfedcba, index 0 first.
    localparam logic [0:15][6:0] SEG_TABLE = {
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };
endpackage

// File: rtl/seven_seg_mux_hex_to_seg.sv
// hex_to_seg: combinational hex nibble to active-high gfedcba segment lookup.
module hex_to_seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);
    assign o_seg = SEG_TABLE[i_nibble];
endmodule

// File: rtl/seven_seg_mux.sv
// seven_seg_mux: two-digit time-multiplexed seven-segment driver with dead time and MS leading-zero blanking.
module seven_seg_mux
    import seven_seg_pkg::*;
#(
    parameter int ON_CYCLES      = 6000,
    parameter int DEAD_CYCLES    = 60,
    parameter bit SEG_ACTIVE_LOW = 1,
    parameter bit DIG_ACTIVE_LOW = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] nibbleMS,
    input  logic [3:0] nibbleLS,
    input  logic       blank_lz,
    output logic [6:0] seg,
    output logic [1:0] dig
);
    localparam int MAXC = ON_CYCLES > DEAD_CYCLES ? ON_CYCLES : DEAD_CYCLES;
    localparam int CW = MAXC > 1 ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] ON_LD = CW'(ON_CYCLES - 1);
    localparam logic [CW-1:0] DEAD_LD = CW'(DEAD_CYCLES > 0 ? DEAD_CYCLES - 1 : 0);
    localparam bit NO_DEAD = DEAD_CYCLES == 0;
    localparam logic [6:0] SEG_POL = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [1:0] DIG_POL = DIG_ACTIVE_LOW ? 2'b11 : 2'b00;

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_ls;
    logic [3:0]    r_ms;
    logic          r_blank;
    logic          w_done;
    logic [1:0]    w_next;
    logic [3:0]    w_ls;
    logic [3:0]    w_ms;
    logic          w_blank;
    logic          w_on_ls;
    logic          w_on_ms;
    logic [3:0]    w_nib;
    logic [6:0]    w_seg;

    // Outputs are computed from the state being entered so they register in step with it.
    always_comb begin
        w_done  = r_cnt == '0;
        w_next  = !w_done ? r_state :
                  r_state == S_LS_ON  ? (NO_DEAD ? S_MS_ON : S_LS_OFF) :
                  r_state == S_LS_OFF ? S_MS_ON :
                  r_state == S_MS_ON  ? (NO_DEAD ? S_LS_ON : S_MS_OFF) : S_LS_ON;
        w_ls    = (w_done && w_next == S_LS_ON) ? nibbleLS : r_ls;
        w_ms    = (w_done && w_next == S_MS_ON) ? nibbleMS : r_ms;
        w_blank = (w_done && w_next == S_MS_ON) ? blank_lz : r_blank;
        w_on_ls = w_next == S_LS_ON;
        w_on_ms = w_next == S_MS_ON && !(w_blank && w_ms == 4'h0);
        w_nib   = w_on_ls ? w_ls : w_ms;
    end

    hex_to_seg u_hex (
        .i_nibble(w_nib),
        .o_seg   (w_seg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_MS_OFF;
            r_cnt   <= '0;
            r_ls    <= '0;
            r_ms    <= '0;
            r_blank <= 1'b0;
            seg     <= SEG_POL;
            dig     <= DIG_POL;
        end else begin
            r_state <= w_next;
            r_cnt   <= !w_done ? r_cnt - 1'b1 :
                       (w_next == S_LS_ON || w_next == S_MS_ON) ? ON_LD : DEAD_LD;
            r_ls    <= w_ls;
            r_ms    <= w_ms;
            r_blank <= w_blank;
            seg     <= ((w_on_ls || w_on_ms) ? w_seg : 7'h00) ^ SEG_POL;
            dig     <= {w_on_ms, w_on_ls} ^ DIG_POL;
        end
    end
endmodule

// File: tb/tb_seven_seg_mux.sv
// tb_seven_seg_mux: directed table-driven bench for the two-digit display mux.
module tb_seven_seg_mux;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] ms = 4'h0;
    logic [3:0] ls = 4'h0;
    logic       blz = 1'b0;
    logic [6:0] seg_a;
    logic [6:0] seg_b;
    logic [1:0] dig_a;
    logic [1:0] dig_b;
    int n_chk = 0;
    int n_pass = 0;

    typedef struct {
        logic [3:0] ms;
        logic [3:0] ls;
        logic       blz;
        logic       ms_dark;
        logic [6:0] ms_seg;
        logic [6:0] ls_seg;
    } vec_t;
    vec_t tbl [19];

    always #5 clk = ~clk;

    seven_seg_mux #(.ON_CYCLES(4), .DEAD_CYCLES(2)) u_a (
        .clk(clk), .rst(rst), .nibbleMS(ms), .nibbleLS(ls), .blank_lz(blz),
        .seg(seg_a), .dig(dig_a)
    );

    seven_seg_mux #(.ON_CYCLES(4), .DEAD_CYCLES(0), .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)) u_b (
        .clk(clk), .rst(rst), .nibbleMS(ms), .nibbleLS(ls), .blank_lz(blz),
        .seg(seg_b), .dig(dig_b)
    );

    always @(negedge clk) begin
        assert (dig_a != 2'b00) else $error("two digits enabled on u_a: dig=%b", dig_a);
        assert (dig_b != 2'b11) else $error("two digits enabled on u_b: dig=%b", dig_b);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int c, input logic [8:0] act, input logic [8:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: seg/dig got %h required %h", nm, c, act, exp);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick;
        tick;
        chk("reset_a", 0, {seg_a, dig_a}, {7'h7F, 2'b11});
        chk("reset_b", 0, {seg_b, dig_b}, {7'h00, 2'b00});
        rst = 1'b0;
    endtask

    initial begin
        logic [8:0] exp;
        int p;
        tbl = '{
            '{4'h0, 4'hF, 1'b0, 1'b0, 7'h3F, 7'h71},
            '{4'h1, 4'hE, 1'b0, 1'b0, 7'h06, 7'h79},
            '{4'h2, 4'hD, 1'b0, 1'b0, 7'h5B, 7'h5E},
            '{4'h3, 4'hC, 1'b0, 1'b0, 7'h4F, 7'h39},
            '{4'h4, 4'hB, 1'b0, 1'b0, 7'h66, 7'h7C},
            '{4'h5, 4'hA, 1'b0, 1'b0, 7'h6D, 7'h77},
            '{4'h6, 4'h9, 1'b0, 1'b0, 7'h7D, 7'h6F},
            '{4'h7, 4'h8, 1'b0, 1'b0, 7'h07, 7'h7F},
            '{4'h8, 4'h7, 1'b0, 1'b0, 7'h7F, 7'h07},
            '{4'h9, 4'h6, 1'b0, 1'b0, 7'h6F, 7'h7D},
            '{4'hA, 4'h5, 1'b0, 1'b0, 7'h77, 7'h6D},
            '{4'hB, 4'h4, 1'b0, 1'b0, 7'h7C, 7'h66},
            '{4'hC, 4'h3, 1'b0, 1'b0, 7'h39, 7'h4F},
            '{4'hD, 4'h2, 1'b0, 1'b0, 7'h5E, 7'h5B},
            '{4'hE, 4'h1, 1'b0, 1'b0, 7'h79, 7'h06},
            '{4'hF, 4'h0, 1'b0, 1'b0, 7'h71, 7'h3F},
            '{4'h4, 4'hA, 1'b0, 1'b0, 7'h66, 7'h77},
            '{4'h0, 4'h5, 1'b1, 1'b1, 7'h00, 7'h6D},
            '{4'h7, 4'h0, 1'b1, 1'b0, 7'h07, 7'h3F}
        };
        // Each vector spans one full 12-cycle period plus the next LS slot entry.
        for (int v = 0; v < 19; v++) begin
            ms  = tbl[v].ms;
            ls  = tbl[v].ls;
            blz = tbl[v].blz;
            do_reset;
            for (int c = 1; c <= 13; c++) begin
                tick;
                p = (c - 1) % 12;
                exp = p < 4 ? {~tbl[v].ls_seg, 2'b10} :
                      (p >= 6 && p < 10) ? (tbl[v].ms_dark ? {7'h7F, 2'b11} : {~tbl[v].ms_seg, 2'b01}) :
                      {7'h7F, 2'b11};
                chk($sformatf("vec%0d", v), c, {seg_a, dig_a}, exp);
            end
        end

        // Mid-slot LS change is held off until the next LS entry.
        ms = 4'h1; ls = 4'h3; blz = 1'b0;
        do_reset;
        tick;
        chk("ls_hold", 1, {seg_a, dig_a}, {~7'h4F, 2'b10});
        ls = 4'h8;
        for (int c = 2; c <= 4; c++) begin
            tick;
            chk("ls_hold", c, {seg_a, dig_a}, {~7'h4F, 2'b10});
        end
        for (int c = 5; c <= 12; c++) tick;
        tick;
        chk("ls_next", 13, {seg_a, dig_a}, {~7'h7F, 2'b10});

        // Reset pulse in the middle of MS_ON.
        ms = 4'h2; ls = 4'h9;
        do_reset;
        for (int c = 1; c <= 8; c++) tick;
        chk("pre_rst_ms", 8, {seg_a, dig_a}, {~7'h5B, 2'b01});
        rst = 1'b1;
        tick;
        chk("mid_rst_a", 9, {seg_a, dig_a}, {7'h7F, 2'b11});
        chk("mid_rst_b", 9, {seg_b, dig_b}, {7'h00, 2'b00});
        rst = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            tick;
            chk("restart_ls", c, {seg_a, dig_a}, {~7'h6F, 2'b10});
        end
        tick;
        chk("restart_dead", 5, {seg_a, dig_a}, {7'h7F, 2'b11});

        // No dead time, active-high polarity.
        ms = 4'h0; ls = 4'h1;
        do_reset;
        for (int c = 1; c <= 16; c++) begin
            tick;
            exp = ((c - 1) / 4) % 2 == 0 ? {7'h06, 2'b01} : {7'h3F, 2'b10};
            chk("nodead", c, {seg_b, dig_b}, exp);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
